current_switch_settle_meter: RTL and testbench
==============================================

Name: current_switch_settle_meter

Overview:
- Sits directly downstream of the current switch model in the emulated analog chain.
- Watches the switch's `ctrl` input and the fixed-point `v_out` it produces.
- Measures how many emulation clock cycles `v_out` takes after each `ctrl` edge to cross a rising or falling threshold.
- Returns each measurement over a valid/ready handshake to the host-side debug logic; a timeout flags edges that never settle.

Parameters:
- V_WIDTH, 18: width of signed fixed-point `v_out` and thresholds (same encoding as the analog signal feeding the switch output).
- CNT_WIDTH, 16: width of the cycle counter and result.
- TIMEOUT, 4095: cycle count at which a measurement ends unsettled. Must be < 2^CNT_WIDTH.

Ports:
- clk  input  1  emulation clock
- rst  input  1  asynchronous, active-high reset
- ctrl  input  1  switch control, same signal driving the current switch
- v_out  input  V_WIDTH  signed fixed-point switch output
- thresh_hi  input  V_WIDTH  signed rising-edge settle threshold
- thresh_lo  input  V_WIDTH  signed falling-edge settle threshold
- meas_valid  output  1  result available
- meas_ready  input  1  consumer accepts result
- meas_cycles  output  CNT_WIDTH  settle latency in clk cycles
- meas_dir  output  1  1 = measured after rising `ctrl` edge, 0 = after falling edge
- meas_timeout  output  1  1 = threshold not crossed within TIMEOUT
- busy  output  1  measurement in progress
- overrun  output  1  sticky: an edge was dropped while a result was unaccepted

Behaviour:
- Reset (async, active-high): `ctrl_d` = 0; state = IDLE; counter = 0; all outputs = 0.
- Edge detection:
  - `ctrl_d` registers `ctrl` each cycle.
  - A rise is `ctrl & ~ctrl_d`; a fall is `~ctrl & ctrl_d`.
  - An edge is evaluated in the cycle it is detected (cycle E).
- States: IDLE, WAIT_HI, WAIT_LO, HOLD.
- IDLE:
  - Rise -> WAIT_HI; fall -> WAIT_LO.
  - Counter loads 0 and direction is latched.
  - `busy` = 1 from cycle E+1.
- WAIT_HI / WAIT_LO, crossing test in every cycle from E onward (including E):
  - WAIT_HI crosses when `v_out >= thresh_hi` (signed compare).
  - WAIT_LO crosses when `v_out <= thresh_lo` (signed compare).
  - `meas_cycles` = cycles elapsed since E at the crossing cycle; a crossing in cycle E gives 0.
  - On crossing: capture result, go to HOLD. `meas_valid` = 1 from the next cycle; `meas_timeout` = 0.
  - If the counter reaches TIMEOUT without a crossing: `meas_cycles` = TIMEOUT, `meas_timeout` = 1, go to HOLD.
  - A new edge while waiting discards the current measurement and restarts with the new direction, counter = 0. No result is emitted for the aborted edge.
- HOLD:
  - `meas_valid`, `meas_cycles`, `meas_dir` and `meas_timeout` stay stable until `meas_valid & meas_ready`.
  - `busy` = 0 in HOLD.
  - An edge in HOLD with no accept in the same cycle is dropped and sets `overrun` = 1. `overrun` clears only on reset.
  - Accept with no edge in the same cycle -> IDLE; `meas_valid` = 0 next cycle.
  - Accept and edge in the same cycle: the edge is honoured and goes directly to WAIT_HI/WAIT_LO as if from IDLE; `overrun` is not set.
- Counter saturates at TIMEOUT and never wraps.
- Thresholds are sampled live every cycle and need not be stable.
- Reset asserted mid-measurement or in HOLD returns immediately to the reset values; the pending result is lost.
- Throughput: one result per edge. Minimum edge spacing for lossless operation is settle time + 1 accept cycle.

Test Plan:
- `thresh_hi`=1000. `ctrl` rises at cycle 10; `v_out` steps 0->1200 at cycle 17; `meas_ready`=1 -> `meas_valid` high at cycle 18 for 1 cycle, `meas_cycles`=7, `meas_dir`=1, `meas_timeout`=0.
- `thresh_lo`=200. `ctrl` falls with `v_out` already at 100 in the edge cycle -> `meas_cycles`=0, `meas_dir`=0.
- TIMEOUT=50, `v_out` held at 0 after a rise -> `meas_cycles`=50, `meas_timeout`=1; the counter never exceeds 50.
- Rise at cycle 0 then fall at cycle 5 before crossing; `v_out`<=`thresh_lo` at cycle 9 -> a single result with `meas_dir`=0, `meas_cycles`=4; no result for the rise.
- `meas_ready`=0 in HOLD: outputs stable for 20 cycles; a `ctrl` edge in that window sets `overrun`=1 and is ignored. A later accept coinciding with an edge starts a new measurement and leaves `overrun` unchanged.
- Assert `rst` during WAIT_HI at counter=30 -> all outputs 0 immediately, state IDLE; the next edge measures from 0.

Source files
------------

// File: rtl/current_switch_settle_meter.sv
// Measures clk cycles from each ctrl edge until v_out crosses the matching
// threshold; results leave over a valid/ready handshake, unsettled edges time out.
module current_switch_settle_meter #(
  parameter int V_WIDTH   = 18,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl,
  input  logic [V_WIDTH-1:0]   v_out,
  input  logic [V_WIDTH-1:0]   thresh_hi,
  input  logic [V_WIDTH-1:0]   thresh_lo,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic [CNT_WIDTH-1:0] meas_cycles,
  output logic                 meas_dir,
  output logic                 meas_timeout,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

  state_t               r_state;
  logic                 r_ctrl_d;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_valid, r_dir, r_tmo, r_busy, r_ovr;
  logic [CNT_WIDTH-1:0] r_cycles;

  logic w_rise, w_fall, w_edge, w_hi_x, w_lo_x, w_start_x, w_wait_x;
  logic w_accept, w_start;

  always_comb begin
    w_rise    = ctrl & ~r_ctrl_d;
    w_fall    = ~ctrl & r_ctrl_d;
    w_edge    = w_rise | w_fall;
    w_hi_x    = $signed(v_out) >= $signed(thresh_hi);
    w_lo_x    = $signed(v_out) <= $signed(thresh_lo);
    w_start_x = w_rise ? w_hi_x : w_lo_x;
    w_wait_x  = (r_state == WAIT_HI) ? w_hi_x : w_lo_x;
    w_accept  = r_valid & meas_ready;
    // An edge restarts measurement anywhere except HOLD, where it needs an accept
    w_start   = w_edge & ((r_state != HOLD) | w_accept);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ctrl_d <= 1'b0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_dir    <= 1'b0;
      r_tmo    <= 1'b0;
      r_busy   <= 1'b0;
      r_ovr    <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_ctrl_d <= ctrl;
      if (w_start) begin
        if (w_start_x) begin
          // Crossing already true in the edge cycle: zero-latency result
          r_state  <= HOLD;
          r_valid  <= 1'b1;
          r_cycles <= '0;
          r_dir    <= w_rise;
          r_tmo    <= 1'b0;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_state <= w_rise ? WAIT_HI : WAIT_LO;
          r_valid <= 1'b0;
          r_busy  <= 1'b1;
          r_cnt   <= CNT_WIDTH'(1);
        end
      end else begin
        case (r_state)
          WAIT_HI, WAIT_LO: begin
            if (w_wait_x || r_cnt == TMO) begin
              r_state  <= HOLD;
              r_valid  <= 1'b1;
              r_cycles <= r_cnt;
              r_dir    <= (r_state == WAIT_HI);
              r_tmo    <= ~w_wait_x;
              r_busy   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
          HOLD: begin
            if (w_accept) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end else if (w_edge) begin
              r_ovr <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign meas_valid   = r_valid;
  assign meas_cycles  = r_cycles;
  assign meas_dir     = r_dir;
  assign meas_timeout = r_tmo;
  assign busy         = r_busy;
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_current_switch_settle_meter.sv
// Directed bench for current_switch_settle_meter with a short timeout.
module tb_current_switch_settle_meter;
  localparam int VW = 18;
  localparam int CW = 16;
  localparam int TO = 50;

  logic                 clk = 1'b0;
  logic                 rst, ctrl, meas_ready;
  logic signed [VW-1:0] v_out, thresh_hi, thresh_lo;
  logic                 meas_valid, meas_dir, meas_timeout, busy, overrun;
  logic [CW-1:0]        meas_cycles;
  int errors = 0;
  int checks = 0;

  current_switch_settle_meter #(.V_WIDTH(VW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .v_out(v_out),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_cycles(meas_cycles),
    .meas_dir(meas_dir), .meas_timeout(meas_timeout), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; ctrl = 1'b0; meas_ready = 1'b1;
    v_out = '0; thresh_hi = 18'sd1000; thresh_lo = 18'sd200;
    step(2);
    checks++; if ({meas_valid, busy, overrun, meas_timeout, meas_dir} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {meas_valid, busy, overrun, meas_timeout, meas_dir}); end
    checks++; if (meas_cycles !== 16'd0) begin errors++; $display("FAIL reset_cycles got %0d want 0", meas_cycles); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_rise_settle;
    ctrl = 1'b1;                        // cycle E
    step(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rise_busy got %b want 1", busy); end
    step(6);                            // cycle E+7
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rise_early_valid got %b want 0", meas_valid); end
    v_out = 18'sd1200;
    step(1);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL rise_valid got %b want 1", meas_valid); end
    checks++; if (meas_cycles !== 16'd7) begin errors++; $display("FAIL rise_cycles got %0d want 7", meas_cycles); end
    checks++; if ({meas_dir, meas_timeout, busy} !== 3'b100) begin errors++; $display("FAIL rise_dir_tmo_busy got %b want 100", {meas_dir, meas_timeout, busy}); end
    step(1);
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rise_valid_drop got %b want 0", meas_valid); end
  endtask

  task automatic test_fall_immediate;
    v_out = 18'sd100; ctrl = 1'b0;
    step(1);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL fall0_valid got %b want 1", meas_valid); end
    checks++; if (meas_cycles !== 16'd0) begin errors++; $display("FAIL fall0_cycles got %0d want 0", meas_cycles); end
    checks++; if ({meas_dir, meas_timeout, busy} !== 3'b000) begin errors++; $display("FAIL fall0_dir_tmo_busy got %b want 000", {meas_dir, meas_timeout, busy}); end
    step(1);
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL fall0_valid_drop got %b want 0", meas_valid); end
  endtask

  task automatic test_abort;
    int early = 0;
    thresh_lo = -18'sd500; v_out = '0;
    ctrl = 1'b1;                        // rise, cycle 0
    for (int i = 0; i < 5; i++) begin step(1); if (meas_valid) early++; end
    ctrl = 1'b0;                        // fall, cycle 5
    for (int i = 0; i < 4; i++) begin step(1); if (meas_valid) early++; end
    v_out = -18'sd600;                  // cycle 9
    checks++; if (early !== 0) begin errors++; $display("FAIL abort_no_rise_result got %0d valid cycles want 0", early); end
    step(1);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL abort_valid got %b want 1", meas_valid); end
    checks++; if (meas_cycles !== 16'd4) begin errors++; $display("FAIL abort_cycles got %0d want 4", meas_cycles); end
    checks++; if (meas_dir !== 1'b0) begin errors++; $display("FAIL abort_dir got %b want 0", meas_dir); end
    early = 0;
    for (int i = 0; i < 3; i++) begin step(1); if (meas_valid) early++; end
    checks++; if (early !== 0) begin errors++; $display("FAIL abort_single_result got %0d extra valid cycles want 0", early); end
    thresh_lo = 18'sd200; v_out = '0;
  endtask

  task automatic test_timeout;
    int early = 0;
    ctrl = 1'b1;
    for (int i = 0; i < TO; i++) begin step(1); if (meas_valid || !busy) early++; end
    checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early got %0d bad cycles want 0", early); end
    step(1);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL tmo_valid got %b want 1", meas_valid); end
    checks++; if (meas_cycles !== 16'd50) begin errors++; $display("FAIL tmo_cycles got %0d want 50", meas_cycles); end
    checks++; if ({meas_timeout, meas_dir} !== 2'b11) begin errors++; $display("FAIL tmo_flag_dir got %b want 11", {meas_timeout, meas_dir}); end
    step(1);
  endtask

  task automatic test_hold_overrun;
    int unstable = 0;
    meas_ready = 1'b0; v_out = 18'sd100; ctrl = 1'b0;   // immediate fall result
    step(1);
    checks++; if ({meas_valid, meas_dir, meas_timeout} !== 3'b100 || meas_cycles !== 16'd0) begin errors++; $display("FAIL hold_result got v%b d%b t%b c%0d want v1 d0 t0 c0", meas_valid, meas_dir, meas_timeout, meas_cycles); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hold_ovr_pre got %b want 0", overrun); end
    for (int i = 0; i < 20; i++) begin
      if (i == 8) ctrl = 1'b1;          // dropped edge
      step(1);
      if (!meas_valid || meas_dir || meas_timeout || meas_cycles != 16'd0 || busy) unstable++;
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL hold_stable got %0d unstable cycles want 0", unstable); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL hold_ovr_set got %b want 1", overrun); end
    meas_ready = 1'b1; ctrl = 1'b0; v_out = 18'sd500;   // accept + fall together
    step(1);
    checks++; if ({meas_valid, busy, overrun} !== 3'b011) begin errors++; $display("FAIL accept_edge got v%b b%b o%b want v0 b1 o1", meas_valid, busy, overrun); end
    v_out = 18'sd100;
    step(1);
    checks++; if (meas_valid !== 1'b1 || meas_cycles !== 16'd1 || meas_dir !== 1'b0) begin errors++; $display("FAIL accept_edge_result got v%b c%0d d%b want v1 c1 d0", meas_valid, meas_cycles, meas_dir); end
    step(1);
  endtask

  task automatic test_reset_mid;
    v_out = '0; ctrl = 1'b1;
    step(30);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({meas_valid, busy, overrun, meas_timeout, meas_dir} !== 5'b0 || meas_cycles !== 16'd0) begin errors++; $display("FAIL rstmid_outputs got %b c%0d want 00000 c0", {meas_valid, busy, overrun, meas_timeout, meas_dir}, meas_cycles); end
    ctrl = 1'b0;
    step(1);
    rst = 1'b0; ctrl = 1'b1;            // cycle E
    step(3);
    v_out = 18'sd1200;
    step(1);
    checks++; if (meas_valid !== 1'b1 || meas_cycles !== 16'd3 || meas_dir !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_next got v%b c%0d d%b o%b want v1 c3 d1 o0", meas_valid, meas_cycles, meas_dir, overrun); end
  endtask

  initial begin
    test_reset;
    test_rise_settle;
    test_fall_immediate;
    test_abort;
    test_timeout;
    test_hold_overrun;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
